// File: rtl/sap_bus_tap_if.sv
// Byte-serial output stream of the SAP-2 bus tap.
//   out_data  : current byte of the head word
//   out_valid : out_data is valid
//   out_ready : consumer accepts the byte when out_valid && out_ready
// master = the tap (producer), slave = the consumer.
interface sap_bus_tap_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/sap_bus_tap.sv
// Capture-and-stream tap for the SAP-2 shared CPU bus.
// Snapshots bus words into a FIFO and streams each word out LSB byte first.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   ena        : capture enable (streaming continues when low)
//   bus_in     : CPU bus value
//   cap_stb    : capture strobe (mode 0)
//   mode       : 0=strobe, 1=on-change, 2=every cycle, 3=hold
//   clr        : synchronous flush of FIFO, beat index and overflow flag
//   out_if     : byte stream (out_data / out_valid / out_ready)
//   overflow   : sticky, a capture was dropped because the FIFO was full
//   fill       : number of words stored, 0..DEPTH
module sap_bus_tap #(
  parameter int unsigned BUS_W = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [BUS_W-1:0]   bus_in,
  input  logic               cap_stb,
  input  logic [1:0]         mode,
  input  logic               clr,
  sap_bus_tap_if.master      out_if,
  output logic               overflow,
  output logic [CNT_W-1:0]   fill
);

  localparam int unsigned NB     = BUS_W / 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned BEAT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    MODE_STROBE = 2'd0,
    MODE_CHANGE = 2'd1,
    MODE_EVERY  = 2'd2,
    MODE_HOLD   = 2'd3
  } cap_mode_e;

  logic [BUS_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_fill;
  logic [BUS_W-1:0]  r_last_bus;
  logic              r_overflow;

  cap_mode_e         w_mode;
  logic              w_cap_req;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_fill_nxt;
  logic [BUS_W-1:0]  w_head;
  logic [7:0]        w_byte;

  assign w_mode  = cap_mode_e'(mode);
  assign w_full  = (r_fill == FULL_CNT);
  assign w_empty = (r_fill == '0);

  always_comb begin
    w_cap_req = 1'b0;
    if (ena) begin
      case (w_mode)
        MODE_STROBE: w_cap_req = cap_stb;
        MODE_CHANGE: w_cap_req = (bus_in != r_last_bus);
        MODE_EVERY:  w_cap_req = 1'b1;
        MODE_HOLD:   w_cap_req = 1'b0;
        default:     w_cap_req = 1'b0;
      endcase
    end
  end

  assign w_accept = !w_empty && out_if.out_ready;
  assign w_pop    = w_accept && (r_beat == LAST_BEAT);
  // A full FIFO still takes the capture when its head word leaves this cycle.
  assign w_push   = w_cap_req && (!w_full || w_pop);
  assign w_drop   = w_cap_req && w_full && !w_pop;

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop)      w_fill_nxt = r_fill + CNT_W'(1);
    else if (!w_push && w_pop) w_fill_nxt = r_fill - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_beat     <= '0;
      r_fill     <= '0;
      r_last_bus <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_last_bus <= bus_in;
      if (clr) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_beat     <= '0;
        r_fill     <= '0;
        r_overflow <= 1'b0;
      end else begin
        r_fill <= w_fill_nxt;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          r_beat   <= '0;
        end else if (w_accept) begin
          r_beat <= r_beat + BEAT_W'(1);
        end
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: it is only observed while fill is non-zero.
  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wr_ptr] <= bus_in;
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_byte = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (r_beat == BEAT_W'(b)) w_byte = w_head[8*b +: 8];
    end
  end

  assign out_if.out_valid = !w_empty;
  assign out_if.out_data  = w_empty ? 8'h00 : w_byte;
  assign overflow         = r_overflow;
  assign fill             = r_fill;

endmodule

// File: tb/tb_sap_bus_tap.sv
module tb_sap_bus_tap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // DUT A: BUS_W=16, DEPTH=8
  logic        a_rst_n, a_ena, a_stb, a_clr, a_ovf;
  logic [15:0] a_bus;
  logic [1:0]  a_mode;
  logic [3:0]  a_fill;
  sap_bus_tap_if a_if ();
  sap_bus_tap #(.BUS_W(16), .DEPTH(8)) u_a (
    .clk(clk), .rst_n(a_rst_n), .ena(a_ena), .bus_in(a_bus), .cap_stb(a_stb),
    .mode(a_mode), .clr(a_clr), .out_if(a_if), .overflow(a_ovf), .fill(a_fill));

  // DUT B: BUS_W=24, DEPTH=4
  logic        b_rst_n, b_ena, b_stb, b_clr, b_ovf;
  logic [23:0] b_bus;
  logic [1:0]  b_mode;
  logic [2:0]  b_fill;
  sap_bus_tap_if b_if ();
  sap_bus_tap #(.BUS_W(24), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(b_rst_n), .ena(b_ena), .bus_in(b_bus), .cap_stb(b_stb),
    .mode(b_mode), .clr(b_clr), .out_if(b_if), .overflow(b_ovf), .fill(b_fill));

  // DUT C: BUS_W=8, DEPTH=4
  logic        c_rst_n, c_ena, c_stb, c_clr, c_ovf;
  logic [7:0]  c_bus;
  logic [1:0]  c_mode;
  logic [2:0]  c_fill;
  sap_bus_tap_if c_if ();
  sap_bus_tap #(.BUS_W(8), .DEPTH(4)) u_c (
    .clk(clk), .rst_n(c_rst_n), .ena(c_ena), .bus_in(c_bus), .cap_stb(c_stb),
    .mode(c_mode), .clr(c_clr), .out_if(c_if), .overflow(c_ovf), .fill(c_fill));

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b_exp [12];
    b_exp = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23,
              8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43};

    a_rst_n = 0; a_ena = 1; a_stb = 0; a_clr = 0; a_bus = '0; a_mode = 2'd3; a_if.out_ready = 0;
    b_rst_n = 0; b_ena = 1; b_stb = 0; b_clr = 0; b_bus = '0; b_mode = 2'd3; b_if.out_ready = 0;
    c_rst_n = 0; c_ena = 1; c_stb = 0; c_clr = 0; c_bus = '0; c_mode = 2'd3; c_if.out_ready = 0;
    tick; tick; tick;
    check_eq("rst_valid", a_if.out_valid, 0);
    check_eq("rst_fill", a_fill, 0);
    check_eq("rst_ovf", a_ovf, 0);
    check_eq("rst_data", a_if.out_data, 0);
    a_rst_n = 1; b_rst_n = 1; c_rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      tick;
      check_eq("idle_valid", a_if.out_valid, 0);
      check_eq("idle_fill", a_fill, 0);
      check_eq("idle_ovf", a_ovf, 0);
      check_eq("idle_data", a_if.out_data, 0);
    end

    // Strobe capture
    a_mode = 2'd0; a_bus = 16'hA55A; a_stb = 1; a_if.out_ready = 1;
    tick; a_stb = 0;
    check_eq("stb_valid0", a_if.out_valid, 1);
    check_eq("stb_byte0", a_if.out_data, 8'h5A);
    check_eq("stb_fill", a_fill, 1);
    tick;
    check_eq("stb_byte1", a_if.out_data, 8'hA5);
    tick;
    check_eq("stb_valid_end", a_if.out_valid, 0);
    check_eq("stb_fill_end", a_fill, 0);
    check_eq("stb_data_end", a_if.out_data, 0);

    // Backpressure
    a_if.out_ready = 0; a_bus = 16'h1234; a_stb = 1;
    tick; a_stb = 0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_data", a_if.out_data, 8'h34);
      check_eq("bp_hold_valid", a_if.out_valid, 1);
      tick;
    end
    a_if.out_ready = 1;
    check_eq("bp_byte0", a_if.out_data, 8'h34);
    tick;
    check_eq("bp_byte1", a_if.out_data, 8'h12);
    tick;
    check_eq("bp_done", a_if.out_valid, 0);

    // On-change
    a_if.out_ready = 0; a_mode = 2'd3; a_bus = 16'h0000;
    tick;
    a_mode = 2'd1;
    a_bus = 16'h0000; tick;
    a_bus = 16'h0000; tick;
    a_bus = 16'h0003; tick;
    a_bus = 16'h0003; tick;
    a_bus = 16'h0003; tick;
    a_bus = 16'h0007; tick;
    a_bus = 16'h0007; tick;
    a_mode = 2'd3;
    check_eq("chg_fill", a_fill, 2);
    a_if.out_ready = 1;
    check_eq("chg_b0", a_if.out_data, 8'h03); tick;
    check_eq("chg_b1", a_if.out_data, 8'h00); tick;
    check_eq("chg_b2", a_if.out_data, 8'h07); tick;
    check_eq("chg_b3", a_if.out_data, 8'h00); tick;
    check_eq("chg_done", a_if.out_valid, 0);

    // ena low blocks capture
    a_ena = 0; a_mode = 2'd2;
    tick; tick; tick;
    check_eq("ena_block", a_fill, 0);
    a_ena = 1;

    // Overflow, then drain the first 8 words
    a_if.out_ready = 0; a_mode = 2'd2;
    for (int i = 0; i < 12; i++) begin
      a_bus = 16'hC000 | 16'(i);
      tick;
    end
    a_mode = 2'd3;
    check_eq("ovf_fill", a_fill, 8);
    check_eq("ovf_flag", a_ovf, 1);
    a_if.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check_eq("ovf_word_lo", a_if.out_data, 32'(i));
      tick;
      check_eq("ovf_word_hi", a_if.out_data, 8'hC0);
      tick;
    end
    check_eq("ovf_drained", a_fill, 0);
    check_eq("ovf_sticky", a_ovf, 1);

    // Overflow again, then clr while full
    a_if.out_ready = 0; a_mode = 2'd2;
    for (int i = 0; i < 12; i++) begin
      a_bus = 16'hD000 | 16'(i);
      tick;
    end
    a_mode = 2'd3;
    check_eq("ovf2_fill", a_fill, 8);
    a_clr = 1; tick; a_clr = 0;
    check_eq("clr_fill", a_fill, 0);
    check_eq("clr_ovf", a_ovf, 0);
    check_eq("clr_valid", a_if.out_valid, 0);

    // DUT B: full with simultaneous pop, NB=3
    b_mode = 2'd0; b_stb = 1;
    b_bus = 24'h030201; tick;
    b_bus = 24'h131211; tick;
    b_bus = 24'h232221; tick;
    b_bus = 24'h333231; tick;
    b_stb = 0;
    check_eq("b_full", b_fill, 4);
    check_eq("b_ovf0", b_ovf, 0);
    b_if.out_ready = 1;
    check_eq("b_w0b0", b_if.out_data, 8'h01); tick;
    check_eq("b_w0b1", b_if.out_data, 8'h02); tick;
    check_eq("b_w0b2", b_if.out_data, 8'h03);
    b_stb = 1; b_bus = 24'h434241;
    tick; b_stb = 0;
    check_eq("b_pp_fill", b_fill, 4);
    check_eq("b_pp_ovf", b_ovf, 0);
    for (int i = 0; i < 12; i++) begin
      check_eq("b_stream", b_if.out_data, b_exp[i]);
      tick;
    end
    check_eq("b_empty", b_if.out_valid, 0);
    b_if.out_ready = 0; b_stb = 1;
    for (int i = 0; i < 5; i++) begin
      b_bus = 24'(i); tick;
    end
    b_stb = 0;
    check_eq("b_drop_fill", b_fill, 4);
    check_eq("b_drop_ovf", b_ovf, 1);

    // DUT C: NB=1, full with simultaneous pop, then async reset mid-stream
    c_mode = 2'd0; c_stb = 1;
    for (int i = 0; i < 4; i++) begin
      c_bus = 8'h10 + 8'(i); tick;
    end
    c_stb = 0;
    check_eq("c_full", c_fill, 4);
    check_eq("c_head", c_if.out_data, 8'h10);
    c_if.out_ready = 1; c_stb = 1; c_bus = 8'h14;
    tick; c_stb = 0; c_if.out_ready = 0;
    check_eq("c_pp_fill", c_fill, 4);
    check_eq("c_pp_ovf", c_ovf, 0);
    check_eq("c_pp_head", c_if.out_data, 8'h11);
    #2 c_rst_n = 0;
    #1;
    check_eq("c_rst_valid", c_if.out_valid, 0);
    check_eq("c_rst_data", c_if.out_data, 0);
    check_eq("c_rst_fill", c_fill, 0);
    check_eq("c_rst_ovf", c_ovf, 0);
    tick;
    c_rst_n = 1;
    c_if.out_ready = 1; c_stb = 1; c_bus = 8'h5C;
    tick; c_stb = 0;
    check_eq("c_new_data", c_if.out_data, 8'h5C);
    check_eq("c_new_fill", c_fill, 1);
    tick;
    check_eq("c_new_done", c_if.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sap_bus_tap.md
Name: sap_bus_tap

Overview:
Parametrised capture-and-stream port for the SAP-2 shared CPU bus. The bus cannot be routed to a top-level inout pin. This block snapshots bus words into a small FIFO and streams them out byte-serially over the 8-bit dedicated outputs with a valid/ready handshake. It sits in the chip top-level wrapper beside the CPU core. It replaces a direct pin connection with a debug/observation channel that works for any bus width and has selectable capture modes.

Parameters:
BUS_W, 16, bus width in bits; multiple of 8, range 8..32
DEPTH, 8, FIFO depth in words; power of 2, >= 2
CNT_W, $clog2(DEPTH)+1, width of the fill-level output

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  capture enable; 0 blocks new captures, streaming continues
bus_in  input  BUS_W  CPU bus value, synchronous to clk
cap_stb  input  1  capture strobe from CPU control (used in mode 0)
mode  input  2  0=strobe, 1=on-change, 2=every cycle, 3=hold (no capture)
clr  input  1  synchronous: flush FIFO, reset beat index, clear overflow
out_data  output  8  current byte of head word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts byte when out_valid && out_ready
overflow  output  1  sticky: at least one capture dropped because the FIFO was full
fill  output  CNT_W  words currently stored, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, rd/wr pointers 0, beat index 0.
  - last_bus register 0.
  - out_valid=0, out_data=0, overflow=0, fill=0.
- Capture request cap_req (combinational), only when ena=1:
  - mode 0: cap_stb.
  - mode 1: bus_in != last_bus.
  - mode 2: 1 every cycle.
  - mode 3: never.
  - last_bus <= bus_in every cycle, regardless of ena or mode.
- Write: cap_req and not full -> bus_in stored at wr_ptr on the clock edge, and wr_ptr increments modulo DEPTH.
- Drop: cap_req and full -> word dropped, overflow <= 1.
- Full with simultaneous pop: if the FIFO is full and the final beat of the head word is accepted in the same cycle, the capture is accepted. fill stays DEPTH and overflow does not set.
- Beats: NB = BUS_W/8 beats per word, sent least-significant byte first.
  - out_data = head[8*beat +: 8], beat index 0..NB-1.
  - out_valid = (fill != 0).
  - out_data is 0 when the FIFO is empty.
- Handshake:
  - out_data and out_valid stay stable while out_valid && !out_ready.
  - Each accepted beat increments beat.
  - Accepting beat NB-1 pops the word (rd_ptr++ modulo DEPTH) and resets beat to 0.
  - No bubble between words: the next word's byte 0 is presented the cycle after the pop.
- Latency: a word captured at edge N is visible with out_valid=1 after edge N, i.e. in cycle N+1, if the FIFO was empty. Minimum 1 cycle, no combinational path from bus_in to out_data.
- Throughput: 1 byte per cycle with out_ready held high. Sustained capture faster than 1 word per NB cycles eventually overflows.
- fill: next fill = fill + push - pop. The registered value is exposed.
- clr:
  - Takes priority over any push or pop in the same cycle.
  - Next state: empty, beat 0, overflow 0.
  - last_bus still updates.
- Reset mid-word: the partial word is lost. Streaming restarts from byte 0 of the next captured word.
- Pointer wrap: pointers wrap modulo DEPTH. full = (fill == DEPTH), empty = (fill == 0).

Test Plan:
- Reset then idle: hold rst_n low, then release with mode=3 -> out_valid=0, fill=0, overflow=0, out_data=0 for 20 cycles.
- Strobe capture, 16-bit: mode 0, bus_in=16'hA55A, one-cycle cap_stb, out_ready=1 -> cycle+1: out_data=8'h5A; next cycle 8'hA5; then out_valid=0, fill back to 0.
- Backpressure: capture 16'h1234, hold out_ready=0 for 5 cycles -> out_data stays 8'h34 with out_valid=1. Raise ready -> 8'h34 then 8'h12, with no duplicate or skipped byte.
- On-change mode: mode 1, bus sequence 0,0,3,3,3,7,7 -> exactly two words captured (3, 7). Streamed bytes are 03,00,07,00.
- Overflow: DEPTH=8, mode 2 for 12 cycles with out_ready=0 -> fill=8, overflow=1, and the FIFO holds the first 8 words. Pulse clr -> fill=0, overflow=0, out_valid=0.
- Full with simultaneous pop and param sweep: BUS_W=24, DEPTH=4. Fill the FIFO, then capture in the same cycle the last beat is accepted -> fill stays 4, overflow=0, bytes LSB first. Repeat with BUS_W=8 (NB=1), with async reset asserted mid-stream -> outputs are 0 immediately after reset asserts.
